prf_read_arbiter: RTL and testbench

//  Shares phys_reg_file read-port pairs (one rs1/rs2 pair per port) among issuing reservation-station slots.

---
 rtl/prf_read_arbiter_pkg.sv | 69 ++++++
 rtl/prf_read_arbiter_rr_grant_select.sv | 45 ++++
 rtl/prf_read_arbiter.sv | 113 +++++++++++
 tb/tb_prf_read_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/prf_read_arbiter_pkg.sv
// Shared types for the PRF read arbiter: widths, pipe record, CDB bypass helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package prf_read_arbiter_pkg;

  localparam int NUM_REQ   = 6;
  localparam int CDB_NUM   = 5;
  localparam int NUM_PORTS = CDB_NUM;
  localparam int P_REG_NUM = 64;
  localparam int IDX_W     = $clog2(P_REG_NUM);
  localparam int REQ_W     = $clog2(NUM_REQ);
  localparam int PORT_W    = $clog2(NUM_PORTS);
  localparam int DATA_W    = 32;

  typedef logic [IDX_W-1:0]  prf_idx_t;
  typedef logic [REQ_W-1:0]  req_id_t;
  typedef logic [DATA_W-1:0] word_t;

  // One read port's worth of state carried from grant cycle to response cycle.
  typedef struct packed {
    logic     valid;
    req_id_t  owner;
    prf_idx_t ps1;
    prf_idx_t ps2;
    logic     byp1;
    logic     byp2;
    word_t    byp1_v;
    word_t    byp2_v;
  } prf_rd_pipe_t;

  typedef struct packed {
    logic  hit;
    word_t data;
  } cdb_hit_t;

  // Ascending lane scan so the highest matching lane wins, mirroring the
  // order in which the register file applies same-edge writes.
  function automatic cdb_hit_t cdb_lookup(
    input prf_idx_t                        ps,
    input logic [CDB_NUM-1:0]              we,
    input logic [CDB_NUM-1:0][IDX_W-1:0]   pd,
    input logic [CDB_NUM-1:0][DATA_W-1:0]  data
  );
    cdb_hit_t r;
    r = '0;
    for (int l = 0; l < CDB_NUM; l++) begin
      if (we[l] && (pd[l] != '0) && (pd[l] == ps)) begin
        r.hit  = 1'b1;
        r.data = data[l];
      end
    end
    return r;
  endfunction

  // Register 0 reads as zero and is never bypassed.
  function automatic word_t operand_sel(
    input prf_idx_t ps,
    input logic     byp,
    input word_t    byp_v,
    input word_t    prf_v
  );
    word_t r;
    if (ps == '0)  r = '0;
    else if (byp)  r = byp_v;
    else           r = prf_v;
    return r;
  endfunction

endpackage

// File: rtl/prf_read_arbiter_rr_grant_select.sv
// Rotate-priority picker: grants up to NUM_PORTS of NUM_REQ requesters starting at rr_ptr_i.
// Latency: combinational. Ports: req_valid_i, rr_ptr_i in; grant_o, port_vld_o,
// port_owner_o (port -> requester), last_o (last granted id), any_o out. No backpressure.
module prf_read_arbiter_rr_grant_select
  import prf_read_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]                req_valid_i,
  input  logic [REQ_W-1:0]                  rr_ptr_i,
  output logic [NUM_REQ-1:0]                grant_o,
  output logic [NUM_PORTS-1:0]              port_vld_o,
  output logic [NUM_PORTS-1:0][REQ_W-1:0]   port_owner_o,
  output logic [REQ_W-1:0]                  last_o,
  output logic                              any_o
);

  logic [PORT_W:0] cnt;
  logic [REQ_W:0]  sum;
  logic [REQ_W-1:0] idx;

  always_comb begin
    grant_o      = '0;
    port_vld_o   = '0;
    port_owner_o = '0;
    last_o       = rr_ptr_i;
    any_o        = 1'b0;
    cnt          = '0;
    sum          = '0;
    idx          = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // (rr_ptr + k) mod NUM_REQ without a divider: sum is below 2*NUM_REQ.
      sum = {1'b0, rr_ptr_i} + (REQ_W+1)'(k);
      if (sum >= (REQ_W+1)'(NUM_REQ)) sum = sum - (REQ_W+1)'(NUM_REQ);
      idx = sum[REQ_W-1:0];
      if (req_valid_i[idx] && (cnt < (PORT_W+1)'(NUM_PORTS))) begin
        grant_o[idx]                    = 1'b1;
        port_vld_o[cnt[PORT_W-1:0]]     = 1'b1;
        port_owner_o[cnt[PORT_W-1:0]]   = idx;
        last_o                          = idx;
        any_o                           = 1'b1;
        cnt                             = cnt + (PORT_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/prf_read_arbiter.sv
// Shares PRF read-port pairs among RS issue slots, round-robin; returns operands one cycle
// after grant with same-edge CDB writes patched in. Latency: 1 cycle grant -> rsp_valid.
// Backpressure: none; requesters must accept responses. Ports: req_* / rsp_* to RS, prf_* to PRF, cdb_* snoop.
module prf_read_arbiter
  import prf_read_arbiter_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][IDX_W-1:0]       req_ps1,
  input  logic [NUM_REQ-1:0][IDX_W-1:0]       req_ps2,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                flush,
  output logic [NUM_PORTS-1:0][IDX_W-1:0]     prf_rs1_s,
  output logic [NUM_PORTS-1:0][IDX_W-1:0]     prf_rs2_s,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]    prf_rs1_v,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]    prf_rs2_v,
  input  logic [CDB_NUM-1:0]                  cdb_we_array,
  input  logic [CDB_NUM-1:0][IDX_W-1:0]       cdb_pd_array,
  input  logic [CDB_NUM-1:0][DATA_W-1:0]      cdb_funct_out_array,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [NUM_REQ-1:0][DATA_W-1:0]      rsp_rs1_v,
  output logic [NUM_REQ-1:0][DATA_W-1:0]      rsp_rs2_v
);

  logic [REQ_W-1:0]                 rr_ptr_q, rr_ptr_d;
  prf_rd_pipe_t [NUM_PORTS-1:0]     pipe_q, pipe_d;
  logic [NUM_REQ-1:0][DATA_W-1:0]   hold1_q, hold2_q;

  logic [NUM_REQ-1:0]               grant;
  logic [NUM_PORTS-1:0]             port_vld;
  logic [NUM_PORTS-1:0][REQ_W-1:0]  port_owner;
  logic [REQ_W-1:0]                 last_granted;
  logic                             any_grant;
  cdb_hit_t [NUM_PORTS-1:0]         hit1, hit2;

  prf_read_arbiter_rr_grant_select u_sel (
    .req_valid_i  (req_valid),
    .rr_ptr_i     (rr_ptr_q),
    .grant_o      (grant),
    .port_vld_o   (port_vld),
    .port_owner_o (port_owner),
    .last_o       (last_granted),
    .any_o        (any_grant)
  );

  assign req_ready = rst ? grant : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (last_granted == REQ_W'(NUM_REQ-1)) ? '0 : last_granted + REQ_W'(1);
    end
  end

  // Cycle 0: drive PRF indices and capture the pipe record, including any
  // CDB write landing on the same edge as the (non write-through) PRF read.
  always_comb begin
    prf_rs1_s = '0;
    prf_rs2_s = '0;
    pipe_d    = '0;
    hit1      = '0;
    hit2      = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rst && port_vld[p]) begin
        prf_rs1_s[p] = req_ps1[port_owner[p]];
        prf_rs2_s[p] = req_ps2[port_owner[p]];
      end
      hit1[p] = cdb_lookup(prf_rs1_s[p], cdb_we_array, cdb_pd_array, cdb_funct_out_array);
      hit2[p] = cdb_lookup(prf_rs2_s[p], cdb_we_array, cdb_pd_array, cdb_funct_out_array);
      // A flush in the grant cycle kills the response but not the grant.
      pipe_d[p].valid  = rst && port_vld[p] && !flush;
      pipe_d[p].owner  = port_owner[p];
      pipe_d[p].ps1    = prf_rs1_s[p];
      pipe_d[p].ps2    = prf_rs2_s[p];
      pipe_d[p].byp1   = hit1[p].hit;
      pipe_d[p].byp2   = hit2[p].hit;
      pipe_d[p].byp1_v = hit1[p].data;
      pipe_d[p].byp2_v = hit2[p].data;
    end
  end

  // Cycle 1: route each port's operands back to its owner; others hold.
  always_comb begin
    rsp_valid = '0;
    rsp_rs1_v = hold1_q;
    rsp_rs2_v = hold2_q;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (pipe_q[p].valid && !flush) begin
        rsp_valid[pipe_q[p].owner] = 1'b1;
        rsp_rs1_v[pipe_q[p].owner] =
          operand_sel(pipe_q[p].ps1, pipe_q[p].byp1, pipe_q[p].byp1_v, prf_rs1_v[p]);
        rsp_rs2_v[pipe_q[p].owner] =
          operand_sel(pipe_q[p].ps2, pipe_q[p].byp2, pipe_q[p].byp2_v, prf_rs2_v[p]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      pipe_q   <= '0;
      hold1_q  <= '0;
      hold2_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      pipe_q   <= pipe_d;
      hold1_q  <= rsp_rs1_v;
      hold2_q  <= rsp_rs2_v;
    end
  end

endmodule

// File: tb/tb_prf_read_arbiter.sv
module tb_prf_read_arbiter;
  import prf_read_arbiter_pkg::*;

  logic                                clk = 1'b0;
  logic                                rst;
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0][IDX_W-1:0]       req_ps1, req_ps2;
  logic [NUM_REQ-1:0]                  req_ready;
  logic                                flush;
  logic [NUM_PORTS-1:0][IDX_W-1:0]     prf_rs1_s, prf_rs2_s;
  logic [NUM_PORTS-1:0][DATA_W-1:0]    prf_rs1_v, prf_rs2_v;
  logic [CDB_NUM-1:0]                  cdb_we;
  logic [CDB_NUM-1:0][IDX_W-1:0]       cdb_pd;
  logic [CDB_NUM-1:0][DATA_W-1:0]      cdb_data;
  logic [NUM_REQ-1:0]                  rsp_valid;
  logic [NUM_REQ-1:0][DATA_W-1:0]      rsp_rs1_v, rsp_rs2_v;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  prf_read_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_ps1             (req_ps1),
    .req_ps2             (req_ps2),
    .req_ready           (req_ready),
    .flush               (flush),
    .prf_rs1_s           (prf_rs1_s),
    .prf_rs2_s           (prf_rs2_s),
    .prf_rs1_v           (prf_rs1_v),
    .prf_rs2_v           (prf_rs2_v),
    .cdb_we_array        (cdb_we),
    .cdb_pd_array        (cdb_pd),
    .cdb_funct_out_array (cdb_data),
    .rsp_valid           (rsp_valid),
    .rsp_rs1_v           (rsp_rs1_v),
    .rsp_rs2_v           (rsp_rs2_v)
  );

  // Register-file model: registered read, no write-through, reg 0 never written.
  logic [P_REG_NUM-1:0]  written;
  logic [DATA_W-1:0]     wmem [P_REG_NUM];

  function automatic logic [DATA_W-1:0] init_val(input int k);
    if (k == 7)      return 32'h11;
    else if (k == 9) return 32'hAA;
    else             return 32'h100 + k;
  endfunction

  function automatic logic [DATA_W-1:0] mem_rd(input logic [IDX_W-1:0] a);
    if (written[a]) return wmem[a];
    return init_val(int'(a));
  endfunction

  always @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      prf_rs1_v[p] <= mem_rd(prf_rs1_s[p]);
      prf_rs2_v[p] <= mem_rd(prf_rs2_s[p]);
    end
    if (!rst) begin
      written <= '0;
    end else begin
      for (int l = 0; l < CDB_NUM; l++) begin
        if (cdb_we[l] && cdb_pd[l] != '0) begin
          wmem[cdb_pd[l]]    <= cdb_data[l];
          written[cdb_pd[l]] <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NUM_REQ-1:0] valid;
    logic [NUM_REQ-1:0] exp_ready;
    logic [NUM_REQ-1:0] exp_rsp;   // responses due from the previous row's grants
  } vec_t;

  vec_t tbl [10];

  initial begin
    // Round-robin walk from rr_ptr=0 right after reset release.
    tbl[0] = '{6'h3F, 6'h1F, 6'h00};
    tbl[1] = '{6'h3F, 6'h2F, 6'h1F};
    tbl[2] = '{6'h3F, 6'h37, 6'h2F};
    tbl[3] = '{6'h00, 6'h00, 6'h37};
    tbl[4] = '{6'h01, 6'h01, 6'h00};
    tbl[5] = '{6'h21, 6'h21, 6'h01};
    tbl[6] = '{6'h03, 6'h03, 6'h21};
    tbl[7] = '{6'h04, 6'h04, 6'h03};
    tbl[8] = '{6'h3F, 6'h3B, 6'h04};
    tbl[9] = '{6'h00, 6'h00, 6'h3B};

    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = 6'h3F;
    cdb_we    = '0;
    cdb_pd    = '0;
    cdb_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ps1[i] = IDX_W'(10 + i);
      req_ps2[i] = IDX_W'(20 + i);
    end

    // Reset held three cycles with every requester asking.
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_prf_rs1_s", 32'(prf_rs1_s), 32'h0);
      check("rst_prf_rs2_s", 32'(prf_rs2_s), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_rs1_v0", rsp_rs1_v[0], 32'h0);
      next_cycle();
    end
    rst = 1'b1;

    for (int v = 0; v < 10; v++) begin
      req_valid = tbl[v].valid;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", v), 32'(req_ready), 32'(tbl[v].exp_ready));
      check($sformatf("tbl%0d_rsp_valid", v), 32'(rsp_valid), 32'(tbl[v].exp_rsp));
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tbl[v].exp_rsp[i]) begin
          check($sformatf("tbl%0d_rs1_%0d", v, i), rsp_rs1_v[i], 32'h100 + 32'(10 + i));
          check($sformatf("tbl%0d_rs2_%0d", v, i), rsp_rs2_v[i], 32'h100 + 32'(20 + i));
        end
      end
      next_cycle();
    end

    // Plain read with a zero second source (rr_ptr=2).
    req_valid  = 6'h04;
    req_ps1[2] = 6'd7;
    req_ps2[2] = 6'd0;
    @(negedge clk);
    check("rd_ready", 32'(req_ready), 32'h04);
    check("rd_port0_idx", 32'(prf_rs1_s[0]), 32'd7);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("rd_rsp_valid", 32'(rsp_valid), 32'h04);
    check("rd_rs1", rsp_rs1_v[2], 32'h11);
    check("rd_rs2", rsp_rs2_v[2], 32'h0);
    next_cycle();

    // Same-edge bypass, two lanes hitting: highest lane wins.
    req_valid   = 6'h02;
    req_ps1[1]  = 6'd9;
    req_ps2[1]  = 6'd0;
    cdb_we      = 5'b11000;
    cdb_pd[3]   = 6'd9;
    cdb_data[3] = 32'h55;
    cdb_pd[4]   = 6'd9;
    cdb_data[4] = 32'h66;
    @(negedge clk);
    check("byp_ready", 32'(req_ready), 32'h02);
    next_cycle();
    req_valid = '0;
    cdb_we    = '0;
    cdb_pd    = '0;
    cdb_data  = '0;
    @(negedge clk);
    check("byp_rsp_valid", 32'(rsp_valid), 32'h02);
    check("byp_rs1", rsp_rs1_v[1], 32'h66);
    next_cycle();

    // A CDB write to p0 must not bypass a read of p0.
    req_valid   = 6'h01;
    req_ps1[0]  = 6'd0;
    req_ps2[0]  = 6'd5;
    cdb_we      = 5'b00001;
    cdb_pd[0]   = 6'd0;
    cdb_data[0] = 32'hFF;
    @(negedge clk);
    check("p0_ready", 32'(req_ready), 32'h01);
    next_cycle();
    req_valid = '0;
    cdb_we    = '0;
    cdb_data  = '0;
    @(negedge clk);
    check("p0_rsp_valid", 32'(rsp_valid), 32'h01);
    check("p0_rs1", rsp_rs1_v[0], 32'h0);
    check("p0_rs2", rsp_rs2_v[0], 32'h105);
    next_cycle();

    // Flush in the response cycle; pointer still moves past req3.
    req_valid = 6'h08;
    @(negedge clk);
    check("fl1_ready", 32'(req_ready), 32'h08);
    next_cycle();
    req_valid = '0;
    flush     = 1'b1;
    @(negedge clk);
    check("fl1_rsp_valid", 32'(rsp_valid), 32'h0);
    check("fl1_rs1_hold", rsp_rs1_v[3], 32'h10D);
    next_cycle();
    flush     = 1'b0;
    req_valid = 6'h3F;
    @(negedge clk);
    check("fl1_resume_ready", 32'(req_ready), 32'h37);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    check("fl1_resume_rsp", 32'(rsp_valid), 32'h37);
    next_cycle();

    // Flush in the grant cycle: grant completes, response is dropped.
    req_valid = 6'h01;
    flush     = 1'b1;
    @(negedge clk);
    check("fl0_ready", 32'(req_ready), 32'h01);
    next_cycle();
    req_valid = '0;
    flush     = 1'b0;
    @(negedge clk);
    check("fl0_rsp_valid", 32'(rsp_valid), 32'h0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
